// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - RV32 load/store initiator onto the word-only memory/MMIO bus
// Sub-word stores via read-modify-write only when LSU_RMW_EN is defined; otherwise SB/SH error out.
module lsu_bus_master #(
  parameter bit RESP_ON_UNSELECTED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        bus_rw,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_selected
);

`ifdef LSU_RMW_EN
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RMW_RD, S_RMW_WR, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

  state_t      state;
  logic        bus_active;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
`ifdef LSU_RMW_EN
  logic [15:0] r_wdata;
  logic [31:0] old_word;
`endif

  logic illegal;
  logic misaligned;
  logic sub_store;

  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                 (req_funct3[2] && req_we);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    sub_store  = req_we && !req_funct3[1];
  end

  // The address register doubles as the bus address; it is gated so the bus reads 0 when idle.
  assign bus_address = bus_active ? {r_addr[31:2], 2'b00} : 32'h0;

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef LSU_RMW_EN
  function automatic logic [31:0] merge(input logic half, input logic [1:0] a,
                                        input logic [15:0] wd, input logic [31:0] old);
    logic [31:0] r;
    r = old;
    if (half) begin
      if (a[1]) r[31:16] = wd;
      else      r[15:0]  = wd;
    end else begin
      r[{a, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'h0;
      resp_error     <= 1'b0;
      bus_rw         <= 1'b0;
      bus_active     <= 1'b0;
      bus_write_data <= 32'h0;
      r_we           <= 1'b0;
      r_funct3       <= 3'b000;
      r_addr         <= 32'h0;
`ifdef LSU_RMW_EN
      r_wdata        <= 16'h0;
      old_word       <= 32'h0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
`ifdef LSU_RMW_EN
            r_wdata   <= req_wdata[15:0];
`endif
            req_ready <= 1'b0;
            if (illegal || misaligned) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (sub_store) begin
`ifdef LSU_RMW_EN
              state      <= S_RMW_RD;
              bus_active <= 1'b1;
              bus_rw     <= 1'b0;
`else
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0;
`endif
            end else begin
              state          <= S_ACCESS;
              bus_active     <= 1'b1;
              bus_rw         <= req_we;
              bus_write_data <= req_we ? req_wdata : 32'h0;
            end
          end
        end
        S_ACCESS: begin
          state          <= S_RESP;
          resp_valid     <= 1'b1;
          bus_active     <= 1'b0;
          bus_rw         <= 1'b0;
          bus_write_data <= 32'h0;
          if (!bus_selected) begin
            resp_error <= RESP_ON_UNSELECTED;
            resp_rdata <= 32'h0;
          end else begin
            resp_error <= 1'b0;
            resp_rdata <= r_we ? 32'h0 : load_ext(r_funct3, r_addr[1:0], bus_read_data);
          end
        end
`ifdef LSU_RMW_EN
        S_RMW_RD: begin
          old_word <= bus_read_data;
          if (!bus_selected) begin
            // Nobody answered the read: never write back a merged garbage word.
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_error <= RESP_ON_UNSELECTED;
            resp_rdata <= 32'h0;
            bus_active <= 1'b0;
          end else begin
            state          <= S_RMW_WR;
            bus_rw         <= 1'b1;
            bus_write_data <= merge(r_funct3[0], r_addr[1:0], r_wdata, bus_read_data);
          end
        end
        S_RMW_WR: begin
          state          <= S_RESP;
          resp_valid     <= 1'b1;
          resp_error     <= !bus_selected && RESP_ON_UNSELECTED;
          resp_rdata     <= 32'h0;
          bus_active     <= 1'b0;
          bus_rw         <= 1'b0;
          bus_write_data <= 32'h0;
        end
`endif
        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: begin
          state          <= S_IDLE;
          req_ready      <= 1'b1;
          bus_active     <= 1'b0;
          bus_rw         <= 1'b0;
          bus_write_data <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - scoreboard bench for lsu_bus_master with a small word memory model
module tb_lsu_bus_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        bus_rw;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_selected;

  lsu_bus_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_rw(bus_rw), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .bus_selected(bus_selected)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'h0;
  int          wr_cnt = 0;
  int          bus_act = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  assign bus_selected  = (bus_address[31:8] == 24'h800000);
  assign bus_read_data = bus_selected ? mem[bus_address[7:2]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (rst_n && bus_rw && bus_selected) begin
      mem[bus_address[7:2]] <= bus_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per resp_valid pulse and tracks any bus activity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_rw || bus_address != 32'h0) bus_act++;
      if (rst_n && resp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=1 required=0");
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_error", {31'h0, resp_error}, {31'h0, e.err});
          chk("latency", cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns at the negedge before the accepting edge unless hold=0, then one negedge later.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic push, input logic [31:0] erd,
                       input logic eerr, input int elat, input logic hold, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else if (push) begin
      e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = acc;
      q.push_back(e);
    end
    if (!hold) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout actual=%0d required=0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, w0, b0;
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2, w0, b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_bus_rw", {31'h0, bus_rw}, 32'h0);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_bus_write_data", bus_write_data, 32'h0);
    rst_n = 1'b1;

    preload(6'd1, 32'h11223344);
    issue(1'b0, 3'b010, 32'h80000004, 32'h0, 1'b1, 32'h11223344, 1'b0, 2, 1'b0, acc);
    drain();

    preload(6'd1, 32'h80FF0011);
    issue(1'b0, 3'b000, 32'h80000007, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 2, 1'b0, acc);
    issue(1'b0, 3'b100, 32'h80000007, 32'h0, 1'b1, 32'h00000080, 1'b0, 2, 1'b0, acc);
    issue(1'b0, 3'b001, 32'h80000006, 32'h0, 1'b1, 32'hFFFF80FF, 1'b0, 2, 1'b0, acc);
    issue(1'b0, 3'b101, 32'h80000006, 32'h0, 1'b1, 32'h000080FF, 1'b0, 2, 1'b0, acc);
    issue(1'b0, 3'b000, 32'h80000004, 32'h0, 1'b1, 32'h00000011, 1'b0, 2, 1'b0, acc);
    drain();

    preload(6'd0, 32'h11223344);
    w0 = wr_cnt;
`ifdef LSU_RMW_EN
    issue(1'b1, 3'b001, 32'h80000002, 32'h1234BEEF, 1'b1, 32'h0, 1'b0, 3, 1'b0, acc);
    drain();
    chk("sh_mem", mem[0], 32'hBEEF3344);
    chk("sh_writes", wr_cnt - w0, 1);
`else
    issue(1'b1, 3'b001, 32'h80000002, 32'h1234BEEF, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc);
    drain();
    chk("sh_mem", mem[0], 32'h11223344);
    chk("sh_writes", wr_cnt - w0, 0);
`endif

    b0 = bus_act;
    issue(1'b0, 3'b010, 32'h80000001, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc);
    issue(1'b0, 3'b001, 32'h80000003, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc);
    issue(1'b0, 3'b011, 32'h80000004, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc);
    issue(1'b1, 3'b100, 32'h80000004, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0, acc);
    drain();
    chk("err_bus_activity", bus_act - b0, 0);

    w0 = wr_cnt;
    issue(1'b1, 3'b010, 32'h00001000, 32'h12345678, 1'b1, 32'h0, 1'b1, 2, 1'b0, acc);
    issue(1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2, 1'b0, acc);
    drain();
    chk("sw_mem", mem[2], 32'hCAFEF00D);
    chk("sw_writes", wr_cnt - w0, 1);

    w0 = wr_cnt;
`ifdef LSU_RMW_EN
    issue(1'b1, 3'b000, 32'h80000009, 32'h000000AA, 1'b0, 32'h0, 1'b0, 0, 1'b0, acc);
    @(negedge clk);
`else
    issue(1'b1, 3'b010, 32'h80000008, 32'h0BADBEEF, 1'b0, 32'h0, 1'b0, 0, 1'b0, acc);
`endif
    chk("mid_bus_rw", {31'h0, bus_rw}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    chk("mid_mem", mem[2], 32'hCAFEF00D);
    chk("mid_writes", wr_cnt - w0, 0);

    preload(6'd1, 32'h11223344);
    preload(6'd3, 32'h55667788);
    issue(1'b0, 3'b010, 32'h80000004, 32'h0, 1'b1, 32'h11223344, 1'b0, 2, 1'b1, acc);
    issue(1'b0, 3'b010, 32'h8000000C, 32'h0, 1'b1, 32'h55667788, 1'b0, 2, 1'b0, acc2);
    drain();
    chk("b2b_accept_gap", acc2 - acc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store bus initiator between the RV32 core's execute stage and the shared memory/MMIO bus. Accepts one load or store request at a time and drives the word-only bus (`rw`, word-aligned address, write data; combinational read data; slave-driven select). Sub-word loads are extracted and sign/zero-extended. Sub-word stores are performed by read-modify-write. Misaligned, unmapped and illegal accesses complete with an error response.

## Interface
Parameters:
- `RESP_ON_UNSELECTED`, 1: 1 = flag `resp_error` when `bus_selected` is low during a bus cycle; 0 = complete silently with data 0.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  0 = load, 1 = store.
- `req_funct3`  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  valid with `resp_valid`.
- `bus_rw`  out  1  0 = read, 1 = write.
- `bus_address`  out  32  `{addr[31:2],2'b00}` during access, else 0.
- `bus_write_data`  out  32  write word.
- `bus_read_data`  in  32  combinational read data from the addressed slave.
- `bus_selected`  in  1  OR of slave select lines.

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE: on `req_valid`, all request fields are registered.
  - Checks on accept, in order:
    - illegal funct3 (011, 110, 111; or 100/101 with `req_we=1`) -> RESP with error.
    - misaligned (H with `addr[0]`; W with `addr[1:0]!=0`) -> RESP with error.
    - sub-word store -> RMW_RD.
    - otherwise -> ACCESS.
- ACCESS:
  - Load: `bus_rw=0`. Select the byte/halfword by `addr[1:0]`, extend it, register the result -> RESP.
  - Word store: `bus_rw=1` and `bus_write_data=wdata` for exactly this cycle -> RESP.
- RMW_RD: `bus_rw=0`; register `bus_read_data` as the old word -> RMW_WR.
- RMW_WR: `bus_rw=1`. `bus_write_data` = old word with byte lane `addr[1:0]` (B) or half-lane `addr[1]` (H) replaced by `wdata[7:0]` / `wdata[15:0]` -> RESP.
- Unselected address:
  - `bus_selected` is sampled in every bus cycle; any low sample sets the sticky error.
  - In RMW_RD with `bus_selected` low: skip RMW_WR (no write issued) -> RESP.
- RESP: `resp_valid=1` for one cycle -> IDLE. `req_ready` stays low in RESP.
- Outside bus states, the bus outputs are `bus_rw=0`, `bus_address=0`, `bus_write_data=0`.

## Timing
- Request accepted at edge E0. Latency is counted from E0 to the cycle where `resp_valid` is high:
  - Load or word store: ACCESS in cycle after E0; `resp_valid` 2 cycles after E0.
  - Sub-word store: RMW_RD, RMW_WR, then `resp_valid` 3 cycles after E0.
  - Error found on accept: `resp_valid` 1 cycle after E0; no bus activity.
- A write takes effect at the rising edge that ends the `bus_rw=1` cycle. `bus_rw=1` is never asserted for more than one cycle per request.
- Request fields are don't-care after acceptance.
- Back-to-back throughput: one request per 3 cycles (load). Next accept is the cycle after RESP.
- Reset values (async, on `rst_n` low):
  - state = IDLE; `req_ready=1`.
  - `resp_valid=0`, `resp_rdata=0`, `resp_error=0`.
  - `bus_rw=0`, `bus_address=0`, `bus_write_data=0`.
  - Registered request and old-word registers = 0.
- Reset mid-operation: the pending request is dropped with no response. A reset asserted in RMW_WR before the edge suppresses the write.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores use RMW_RD/RMW_WR as above.
- `LSU_RMW_EN` undefined:
  - RMW_RD and RMW_WR states are not built.
  - SB/SH complete through RESP with `resp_error=1` and no bus activity, 1 cycle after accept.
  - Word stores and all loads are unchanged.

## Test plan
- LW at 0x80000004, mem word 0x11223344 -> `resp_rdata=0x11223344`, `resp_error=0`, `resp_valid` 2 cycles after accept.
- LB at 0x80000007 and LBU at 0x80000007, mem word 0x80FF0011 -> `resp_rdata` 0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH 0xBEEF at 0x80000002 over 0x11223344 (`LSU_RMW_EN`) -> one write of 0xBEEF3344; `resp_valid` 3 cycles after accept. Without the macro: error and no write.
- LW at 0x80000001 -> `resp_error=1` after 1 cycle, `bus_rw`/`bus_address` stay 0. SW at 0x00001000 (unselected) -> `resp_error=1`.
- Assert `rst_n` low during RMW_WR of SB -> no write (memory unchanged), `resp_valid` never pulses, `req_ready=1` after release.
- Two back-to-back LWs with `req_valid` held -> second accepted the cycle after the first RESP; responses in order.
